// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet helpers: flit control layout, flit sizing and control-bit generation.
package noc_pkt_pkg;

    // Every flit carries three control bits above its payload.
    localparam int unsigned FLIT_CTRL_BITS = 3;
    // Control bit positions, counted down from the flit MSB (bit FW-1 is VALID).
    localparam int unsigned VALID_FROM_MSB = 1;
    localparam int unsigned HEAD_FROM_MSB  = 2;
    localparam int unsigned TAIL_FROM_MSB  = 3;

    typedef struct packed {
        logic valid;
        logic head;
        logic tail;
    } flit_ctrl_t;

    function automatic int unsigned flit_width(input int unsigned wpkt, input int unsigned nflit);
        return wpkt / nflit;
    endfunction

    // Flits needed to carry pl payload bits; a huge value flags an unusable flit width.
    function automatic int unsigned used_flits(input int unsigned pl, input int unsigned fw);
        if (fw <= FLIT_CTRL_BITS) begin
            return 32'hFFFF;
        end
        return (pl + (fw - FLIT_CTRL_BITS) - 1) / (fw - FLIT_CTRL_BITS);
    endfunction

    // Control bits of flit idx in a packet of n used flits; unused flits are all zero.
    function automatic flit_ctrl_t flit_ctrl(input int unsigned idx, input int unsigned n);
        flit_ctrl_t c;
        c.valid = (idx < n);
        c.head  = (idx == 0) && (idx < n);
        c.tail  = (idx + 1 == n);
        return c;
    endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// Generic 2-entry registered FIFO with a registered upstream ready.
module pkt_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_push = i_valid && r_ready;
    assign w_pop  = o_valid && i_ready;

    // Occupancy after this cycle's push/pop; push and pop together leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Storage, 1-bit wrapping pointers, count and ready; reset drops queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_nxt;
            // Registered so ready never depends combinationally on i_ready.
            r_ready <= (w_count_nxt < 2'd2);
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_ready = r_ready;

endmodule

// File: rtl/packetizer_da.sv
// Dest-append packetizer: formats one packet word of flits and queues it toward the NoC.
module packetizer_da
    import noc_pkt_pkg::*;
#(
    parameter int unsigned WIDTH_PKT        = 36,
    parameter int unsigned WIDTH_DATA       = 12,
    parameter int unsigned VC_ADDRESS_WIDTH = 1,
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned PACKETIZER_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_DATA-1:0]       data_in,
    input  logic [ADDRESS_WIDTH-1:0]    dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
    input  logic [ADDRESS_WIDTH-1:0]    return_dst_in,
    input  logic [VC_ADDRESS_WIDTH-1:0] return_vc_in,
    input  logic                        valid_in,
    output logic                        ready_out,
    output logic [WIDTH_PKT-1:0]        data_out,
    output logic                        valid_out,
    input  logic                        ready_in
);

    localparam int unsigned FW = flit_width(WIDTH_PKT, PACKETIZER_WIDTH);
    localparam int unsigned PW = FW - FLIT_CTRL_BITS;
    localparam int unsigned PL = 2 * (ADDRESS_WIDTH + VC_ADDRESS_WIDTH) + WIDTH_DATA;
    localparam int unsigned N  = used_flits(PL, FW);
    localparam int unsigned SW = N * PW;

    if (PACKETIZER_WIDTH != 1 && PACKETIZER_WIDTH != 2 && PACKETIZER_WIDTH != 4) begin : g_chk_pw
        $error("PACKETIZER_WIDTH must be 1, 2 or 4");
    end
    if (WIDTH_PKT % PACKETIZER_WIDTH != 0) begin : g_chk_div
        $error("WIDTH_PKT must be divisible by PACKETIZER_WIDTH");
    end
    if (FW < FLIT_CTRL_BITS + ADDRESS_WIDTH + VC_ADDRESS_WIDTH) begin : g_chk_fw
        $error("flit payload too narrow for destination and VC");
    end
    if (N > PACKETIZER_WIDTH) begin : g_chk_n
        $error("payload does not fit in PACKETIZER_WIDTH flits");
    end

    logic [PL-1:0]        w_stream;
    logic [SW-1:0]        w_pad;
    logic [WIDTH_PKT-1:0] w_pkt;

    assign w_stream = {dst_in, vc_in, return_dst_in, return_vc_in, data_in};
    // Left-justify the stream so the zero padding lands at the LSB end of the last flit.
    assign w_pad    = SW'(w_stream) << (SW - PL);

    // Flit 0 sits at the MSB end; flits beyond the used count are all zero.
    for (genvar gi = 0; gi < PACKETIZER_WIDTH; gi++) begin : g_flit
        if (gi < N) begin : g_used
            assign w_pkt[WIDTH_PKT-1-gi*FW -: FW] = {flit_ctrl(gi, N), w_pad[SW-1-gi*PW -: PW]};
        end else begin : g_unused
            assign w_pkt[WIDTH_PKT-1-gi*FW -: FW] = '0;
        end
    end

    pkt_fifo2 #(
        .WIDTH (WIDTH_PKT)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_pkt),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .o_data  (data_out),
        .o_valid (valid_out),
        .i_ready (ready_in)
    );

endmodule
